ring_digit_sel: RTL and testbench
=================================

RING_DIGIT_SEL -- requirements
Module: ring_digit_sel

Interface
REQ-001 Parameter NUM_DIGITS, default 4, digits in the rotating ring; legal range 2..8.
REQ-002 Parameter AN_W, default 8, anode bus width; AN_W >= NUM_DIGITS.
REQ-003 Localparam STEPS = 2*NUM_DIGITS, positions per full rotation; PW = $clog2(STEPS).
REQ-004 clk  input  1  single system clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 tic  input  1  one-clk step strobe from the rate divider; advance only when tic=1.
REQ-007 En  input  1  run enable; 0 = pause, position held.
REQ-008 Cw  input  1  direction; 1 = clockwise (increment), 0 = counterclockwise (decrement).
REQ-009 mode  input  1  0 = continuous rotation, 1 = single-lap.
REQ-010 start  input  1  single-lap launch strobe; used only when mode=1.
REQ-011 clr  input  1  synchronous clear of position and lap state.
REQ-012 An  output  AN_W  active-low digit enables, exactly one low bit.
REQ-013 side  output  1  rotation half: 0 = first half, 1 = second half.
REQ-014 pos  output  PW  current ring position 0..STEPS-1.
REQ-015 lap  output  1  one-clk pulse when a full rotation completes.
REQ-016 busy  output  1  block advancing on the next tic.

Function
REQ-017 pos SHALL be a registered counter, always within 0..STEPS-1.
REQ-018 Advance condition SHALL be tic & En & (mode==0 | state==RUN); otherwise pos holds.
REQ-019 On advance with Cw=1: pos+1, STEPS-1 wraps to 0; with Cw=0: pos-1, 0 wraps to STEPS-1.
REQ-020 Wrap SHALL be explicit compare, not binary overflow (STEPS need not be a power of two).
REQ-021 Digit index d SHALL be pos when pos<NUM_DIGITS, else STEPS-1-pos.
REQ-022 An[d] SHALL be 0; all other An bits, including An[AN_W-1:NUM_DIGITS], SHALL be 1; An combinational from pos.
REQ-023 side SHALL be 1 iff pos >= NUM_DIGITS.
REQ-024 lap SHALL be registered, asserted for exactly one clk in the cycle after an advance that wraps (either direction).
REQ-025 State machine, two states STOP and RUN; state used only for mode=1 gating.
REQ-026 STOP -> RUN when mode=1 & start=1 & clr=0; start ignored while RUN.
REQ-027 RUN -> STOP on the same edge as a wrapping advance in mode=1; pos lands on 0 (Cw=1) or STEPS-1 (Cw=0).
REQ-028 In mode=0, state SHALL be forced to STOP; continuous rotation ignores start.
REQ-029 busy SHALL equal En & (mode==0 | state==RUN).
REQ-030 En=0 SHALL pause without altering pos or state (differs from reset-on-pause of the previous generation).
REQ-031 Cw change mid-rotation SHALL take effect on the next advance; no extra step, no skip.
REQ-032 clr=1: pos<=0, state<=STOP, lap<=0 on that edge; clr overrides tic, start and wrap.
REQ-033 mode change 1->0 during RUN: state to STOP next edge, rotation continues if En=1.

Reset
REQ-034 rst_n=0 SHALL immediately force pos=0, state=STOP, lap=0, independent of clk.
REQ-035 During and after reset: An = all ones except An[0]=0, side=0, busy=En&~mode.
REQ-036 Reset deassertion mid-rotation SHALL resume from pos=0 on first qualifying tic.

Verification
REQ-037 NUM_DIGITS=4, mode=0, En=1, Cw=1, 9 tics -> pos 1..7,0,1; An[3:0] 1101,1011,0111,0111,1011,1101,1110,1110,1101; lap pulse once after 8th tic; side 1 for pos 4..7.
REQ-038 NUM_DIGITS=3, Cw=0 from reset, 1 tic -> pos=5, An[2:0]=110, side=1, lap=1 one clk; An[7:3]=11111.
REQ-039 mode=1, start pulse, 8 tics Cw=1 -> busy 1 through 8th tic, then STOP, pos=0, lap once; 9th tic -> pos stays 0.
REQ-040 Mid-run En=0 for 5 tics at pos=3 -> pos stays 3, busy=0; En=1 next tic -> pos=4.
REQ-041 clr and start asserted same edge with tic, pos=6 -> pos=0, state STOP, lap=0; rst_n low mid-clk -> outputs reset before next edge.

Source files
------------

// File: rtl/ring_digit_sel.sv
// ring_digit_sel: rotating ring position counter driving one active-low
// digit enable, with continuous and single-lap modes and a lap pulse.
module ring_digit_sel #(
    parameter int NUM_DIGITS = 4,
    parameter int AN_W       = 8,
    localparam int STEPS     = 2 * NUM_DIGITS,
    localparam int PW        = $clog2(STEPS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            tic,
    input  logic            En,
    input  logic            Cw,
    input  logic            mode,
    input  logic            start,
    input  logic            clr,
    output logic [AN_W-1:0] An,
    output logic            side,
    output logic [PW-1:0]   pos,
    output logic            lap,
    output logic            busy
);

    typedef enum logic {
        STOP = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [PW-1:0] LAST = PW'(STEPS - 1);
    localparam logic [PW-1:0] HALF = PW'(NUM_DIGITS);

    state_t          state, state_nx;
    logic [PW-1:0]   pos_nx;
    logic [PW-1:0]   d;
    logic            adv;
    logic            wrap;

    assign busy = En & (~mode | (state == RUN));
    assign adv  = tic & busy;
    assign wrap = adv & (Cw ? (pos == LAST) : (pos == '0));

    // Next position: explicit wrap compare in both directions, clr wins.
    always_comb begin
        pos_nx = pos;
        if (clr) begin
            pos_nx = '0;
        end else if (adv) begin
            if (Cw) pos_nx = (pos == LAST) ? '0 : pos + 1'b1;
            else    pos_nx = (pos == '0) ? LAST : pos - 1'b1;
        end
    end

    // Lap gating: a launch arms one rotation, a wrap ends it.
    always_comb begin
        state_nx = state;
        if (clr || !mode) begin
            state_nx = STOP;
        end else begin
            unique case (state)
                STOP: if (start) state_nx = RUN;
                RUN:  if (wrap)  state_nx = STOP;
                default: state_nx = STOP;
            endcase
        end
    end

    // Position, lap pulse and lap state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos   <= '0;
            lap   <= 1'b0;
            state <= STOP;
        end else begin
            pos   <= pos_nx;
            lap   <= wrap & ~clr;
            state <= state_nx;
        end
    end

    // Second half of the ring walks the digits back down.
    always_comb begin
        d  = (pos < HALF) ? pos : LAST - pos;
        An = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            An[i] = (PW'(i) != d);
        end
    end

    assign side = (pos >= HALF);

endmodule

// File: tb/tb_ring_digit_sel.sv
// tb_ring_digit_sel: directed vector table plus hand sequences for
// reset, single-lap and a 3-digit instance.
module tb_ring_digit_sel;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tic, En, Cw, mode, start, clr;
    logic [7:0] an4, an3;
    logic [2:0] pos4, pos3;
    logic       side4, side3, lap4, lap3, busy4, busy3;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ring_digit_sel u4 (
        .clk(clk), .rst_n(rst_n), .tic(tic), .En(En), .Cw(Cw),
        .mode(mode), .start(start), .clr(clr),
        .An(an4), .side(side4), .pos(pos4), .lap(lap4), .busy(busy4)
    );

    ring_digit_sel #(.NUM_DIGITS(3), .AN_W(8)) u3 (
        .clk(clk), .rst_n(rst_n), .tic(tic), .En(En), .Cw(Cw),
        .mode(mode), .start(start), .clr(clr),
        .An(an3), .side(side3), .pos(pos3), .lap(lap3), .busy(busy3)
    );

    typedef struct {
        logic       tic, en, cw, mode, start, clr;
        logic [2:0] pos;
        logic [7:0] an;
        logic       side, lap, busy;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(
        input logic t, e, c, m, s, k,
        input logic [2:0] p, input logic [7:0] a,
        input logic sd, lp, b
    );
        vec_t r;
        r.tic = t; r.en = e; r.cw = c; r.mode = m;
        r.start = s; r.clr = k; r.pos = p; r.an = a;
        r.side = sd; r.lap = lp; r.busy = b;
        return r;
    endfunction

    task automatic chk(input string nm, input int idx,
                       input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s [%0d] got=%h want=%h", nm, idx, got, exp);
        end
    endtask

    task automatic chk4(input string nm, input int idx,
                        input logic [2:0] p, input logic [7:0] a,
                        input logic sd, lp, b);
        chk({nm, ".pos"}, idx, {5'd0, pos4}, {5'd0, p});
        chk({nm, ".An"}, idx, an4, a);
        chk({nm, ".side"}, idx, {7'd0, side4}, {7'd0, sd});
        chk({nm, ".lap"}, idx, {7'd0, lap4}, {7'd0, lp});
        chk({nm, ".busy"}, idx, {7'd0, busy4}, {7'd0, b});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; tic = 0; En = 1; Cw = 1;
        mode = 0; start = 0; clr = 0;
        #12;
        chk4("reset", 0, 3'd0, 8'hFE, 1'b0, 1'b0, 1'b1);

        // 3-digit ring, counterclockwise from reset.
        @(negedge clk);
        rst_n = 1'b1; Cw = 0; tic = 1;
        step();
        chk("u3.pos", 0, {5'd0, pos3}, 8'd5);
        chk("u3.An", 0, an3, 8'hFE);
        chk("u3.side", 0, {7'd0, side3}, 8'd1);
        chk("u3.lap", 0, {7'd0, lap3}, 8'd1);
        tic = 0;
        step();
        chk("u3.lap", 1, {7'd0, lap3}, 8'd0);
        chk("u3.pos", 1, {5'd0, pos3}, 8'd5);

        rst_n = 1'b0; Cw = 1;
        #1;
        chk4("rst2", 0, 3'd0, 8'hFE, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;

        // continuous clockwise lap
        tbl.push_back(v(1,1,1,0,0,0, 3'd1, 8'hFD, 0,0,1));
        tbl.push_back(v(1,1,1,0,0,0, 3'd2, 8'hFB, 0,0,1));
        tbl.push_back(v(1,1,1,0,0,0, 3'd3, 8'hF7, 0,0,1));
        tbl.push_back(v(1,1,1,0,0,0, 3'd4, 8'hF7, 1,0,1));
        tbl.push_back(v(1,1,1,0,0,0, 3'd5, 8'hFB, 1,0,1));
        tbl.push_back(v(1,1,1,0,0,0, 3'd6, 8'hFD, 1,0,1));
        tbl.push_back(v(1,1,1,0,0,0, 3'd7, 8'hFE, 1,0,1));
        tbl.push_back(v(1,1,1,0,0,0, 3'd0, 8'hFE, 0,1,1));
        tbl.push_back(v(1,1,1,0,0,0, 3'd1, 8'hFD, 0,0,1));
        // no tic, then direction flips across the wrap point
        tbl.push_back(v(0,1,1,0,0,0, 3'd1, 8'hFD, 0,0,1));
        tbl.push_back(v(1,1,0,0,0,0, 3'd0, 8'hFE, 0,0,1));
        tbl.push_back(v(1,1,0,0,0,0, 3'd7, 8'hFE, 1,1,1));
        tbl.push_back(v(1,1,1,0,0,0, 3'd0, 8'hFE, 0,1,1));
        tbl.push_back(v(1,1,0,0,0,0, 3'd7, 8'hFE, 1,1,1));
        // clr beats a wrapping advance
        tbl.push_back(v(1,1,1,0,0,1, 3'd0, 8'hFE, 0,0,1));
        tbl.push_back(v(1,0,1,0,0,0, 3'd0, 8'hFE, 0,0,0));
        // single-lap mode
        tbl.push_back(v(1,1,1,1,0,0, 3'd0, 8'hFE, 0,0,0));
        tbl.push_back(v(0,1,1,1,1,0, 3'd0, 8'hFE, 0,0,1));
        tbl.push_back(v(1,1,1,1,0,0, 3'd1, 8'hFD, 0,0,1));
        tbl.push_back(v(1,1,1,1,0,0, 3'd2, 8'hFB, 0,0,1));
        tbl.push_back(v(1,1,1,1,0,0, 3'd3, 8'hF7, 0,0,1));
        tbl.push_back(v(1,1,1,1,0,0, 3'd4, 8'hF7, 1,0,1));
        tbl.push_back(v(1,1,1,1,0,0, 3'd5, 8'hFB, 1,0,1));
        tbl.push_back(v(1,1,1,1,0,0, 3'd6, 8'hFD, 1,0,1));
        tbl.push_back(v(1,1,1,1,0,0, 3'd7, 8'hFE, 1,0,1));
        tbl.push_back(v(1,1,1,1,0,0, 3'd0, 8'hFE, 0,1,0));
        tbl.push_back(v(1,1,1,1,0,0, 3'd0, 8'hFE, 0,0,0));
        // relaunch, pause mid-run, resume
        tbl.push_back(v(0,1,1,1,1,0, 3'd0, 8'hFE, 0,0,1));
        tbl.push_back(v(1,1,1,1,0,0, 3'd1, 8'hFD, 0,0,1));
        tbl.push_back(v(1,1,1,1,0,0, 3'd2, 8'hFB, 0,0,1));
        tbl.push_back(v(1,1,1,1,0,0, 3'd3, 8'hF7, 0,0,1));
        for (int i = 0; i < 5; i++)
            tbl.push_back(v(1,0,1,1,0,0, 3'd3, 8'hF7, 0,0,0));
        tbl.push_back(v(1,1,1,1,0,0, 3'd4, 8'hF7, 1,0,1));
        // mode 1->0 during RUN keeps rotating, state drops to STOP
        tbl.push_back(v(1,1,1,0,0,0, 3'd5, 8'hFB, 1,0,1));
        tbl.push_back(v(1,1,1,1,0,0, 3'd5, 8'hFB, 1,0,0));
        tbl.push_back(v(1,1,1,0,0,0, 3'd6, 8'hFD, 1,0,1));
        // clr with start and tic at pos 6
        tbl.push_back(v(1,1,1,1,1,1, 3'd0, 8'hFE, 0,0,0));
        tbl.push_back(v(1,1,1,1,0,0, 3'd0, 8'hFE, 0,0,0));

        foreach (tbl[i]) begin
            tic = tbl[i].tic; En = tbl[i].en; Cw = tbl[i].cw;
            mode = tbl[i].mode; start = tbl[i].start; clr = tbl[i].clr;
            step();
            chk4("vec", i, tbl[i].pos, tbl[i].an,
                 tbl[i].side, tbl[i].lap, tbl[i].busy);
        end

        // asynchronous reset in the middle of a clock period
        tic = 1; En = 1; Cw = 1; mode = 0; start = 0; clr = 0;
        step();
        step();
        chk4("pre_rst", 0, 3'd2, 8'hFB, 1'b0, 1'b0, 1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        chk4("async_rst", 0, 3'd0, 8'hFE, 1'b0, 1'b0, 1'b1);
        mode = 1;
        #1;
        chk("async_rst.busy_m1", 0, {7'd0, busy4}, 8'd0);
        @(negedge clk);
        rst_n = 1'b1; mode = 0;
        step();
        chk4("resume", 0, 3'd1, 8'hFD, 1'b0, 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
